// File: rtl/fib_pkg.sv
// Shared types and defaults for the fib_drain countdown sampler.
//   state_e    : RUN (draining) / DONE (idle, waiting for a load)
//   W_DEF      : default datapath width for n, x, m and sample data
//   INIT_N_DEF : default bound loaded at reset
package fib_pkg;

    localparam int unsigned W_DEF      = 11;
    localparam int unsigned INIT_N_DEF = 200;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage : fib_pkg

// File: rtl/fib_drain_if.sv
// Valid/ready sample port carrying captured counter values.
//   sample_valid : producer holds an unconsumed capture
//   sample_ready : consumer accepts sample_data this cycle
//   sample_data  : captured value, stable while valid && !ready
// master = producer (fib_drain), slave = consumer.
interface fib_drain_if #(
    parameter int unsigned W = fib_pkg::W_DEF
);

    logic         sample_valid;
    logic         sample_ready;
    logic [W-1:0] sample_data;

    modport master (
        output sample_valid,
        output sample_data,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output sample_ready
    );

endinterface : fib_drain_if

// File: rtl/fib_sample_slot.sv
// Single-entry valid/ready holding register for captured samples.
//   clk, rst     : clock, synchronous active-low reset
//   load_i       : write data_i into the slot (caller only loads when slot_free_c)
//   data_i       : value to capture
//   ready_i      : consumer accepts the held value
//   slot_free_c  : slot can take a new value this cycle (empty or draining now)
//   valid_o      : slot holds an unconsumed value
//   data_o       : held value
module fib_sample_slot #(
    parameter int unsigned W = fib_pkg::W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         slot_free_c,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // A transfer this cycle frees the slot, so a same-cycle load replaces the data.
    assign slot_free_c = !valid_q || ready_i;

    // Next-state: load wins, otherwise a transfer empties the slot; data only moves on load.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : fib_sample_slot

// File: rtl/fib_drain.sv
// Countdown sampler: drains x from bound n to 0, one step per cycle, with an
// optional capture of x into m published on a back-pressurable sample port.
//   clk          : clock
//   rst          : synchronous active-low reset (loads INIT_N, enters RUN)
//   selector     : request to capture x this cycle
//   start        : load request, honoured only in DONE
//   n_in         : new bound, sampled when start is honoured
//   smp          : sample port (sample_valid/sample_data out, sample_ready in)
//   m            : last captured x (0 after reset/load)
//   n            : current bound
//   x            : current count
//   busy / done  : state decode (RUN / DONE)
module fib_drain
    import fib_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned INIT_N = INIT_N_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          selector,
    input  logic          start,
    input  logic [W-1:0]  n_in,
    fib_drain_if.master   smp,
    output logic [W-1:0]  m,
    output logic [W-1:0]  n,
    output logic [W-1:0]  x,
    output logic          busy,
    output logic          done
);

    localparam logic [W-1:0] INIT_V = W'(INIT_N);
    localparam logic [W-1:0] ONE_V  = W'(1);

    state_e       state_q, state_d;
    logic [W-1:0] n_q, n_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] m_q, m_d;
    logic         capture_c;
    logic         slot_free_c;

    // Next-state and capture decision.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        x_d       = x_q;
        m_d       = m_q;
        capture_c = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (x_q == '0) begin
                    // Zero is never captured; selector is ignored here.
                    state_d = ST_DONE;
                end else if (selector && !slot_free_c) begin
                    // Stall: the pending sample has not been consumed yet.
                    state_d = ST_RUN;
                end else begin
                    x_d = x_q - ONE_V;
                    if (selector) begin
                        capture_c = 1'b1;
                        m_d       = x_q;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    n_d     = n_in;
                    x_d     = n_in;
                    m_d     = '0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // State and datapath registers; reset overrides all inputs in any state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            n_q     <= INIT_V;
            x_q     <= INIT_V;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            x_q     <= x_d;
            m_q     <= m_d;
        end
    end

    // Holding register for the published sample.
    fib_sample_slot #(
        .W (W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (capture_c),
        .data_i      (x_q),
        .ready_i     (smp.sample_ready),
        .slot_free_c (slot_free_c),
        .valid_o     (smp.sample_valid),
        .data_o      (smp.sample_data)
    );

    assign m    = m_q;
    assign n    = n_q;
    assign x    = x_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule : fib_drain
